// File: rtl/zspi_pkg.sv
// Shared definitions for the zspi SPI master: FSM encoding, SPI mode codes
// and a ceiling-log2 helper used to size the edge counter.
package zspi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    // SPI modes encoded as {cpol, cpha}
    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    function automatic int clog2(input int value);
        int result = 0;
        while ((1 << result) < value) result++;
        return result;
    endfunction

endpackage

// File: rtl/zspi_clkgen.sv
// SCK timing for zspi_master: a prescaler that wraps every (div+1) cycles and
// a counter of SCK edges within one transfer (0 .. 2*DW-1).
module zspi_clkgen
    import zspi_pkg::*;
#(
    parameter int DW   = 8,
    parameter int DIVW = 8,
    parameter int EW   = clog2(2 * DW)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            en,
    input  logic [DIVW-1:0] div,
    output logic            edge_stb,
    output logic [EW-1:0]   edge_idx,
    output logic            last_edge
);

    localparam logic [EW-1:0] LAST_IDX = EW'(2 * DW - 1);

    logic [DIVW-1:0] pre_q, pre_d;
    logic [EW-1:0]   idx_q, idx_d;

    // Prescaler wraps on equality with div, so div = all-ones never overflows
    always_comb begin
        pre_d     = pre_q;
        idx_d     = idx_q;
        edge_stb  = en && (pre_q == div);
        last_edge = edge_stb && (idx_q == LAST_IDX);
        edge_idx  = idx_q;
        if (clr) begin
            pre_d = '0;
            idx_d = '0;
        end else if (en) begin
            if (edge_stb) begin
                pre_d = '0;
                idx_d = idx_q + EW'(1);
            end else begin
                pre_d = pre_q + DIVW'(1);
            end
        end
    end

    // Counter state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q <= '0;
            idx_q <= '0;
        end else begin
            pre_q <= pre_d;
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/zspi_master.sv
// Parametrised SPI master: configurable word width, runtime divider, all four
// CPOL/CPHA modes, software-controlled chip selects, start/busy/done handshake.
module zspi_master
    import zspi_pkg::*;
#(
    parameter int DW   = 8,
    parameter int NCS  = 2,
    parameter int DIVW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [DW-1:0]   din,
    input  logic            start,
    input  logic [DIVW-1:0] div,
    input  logic            cpol,
    input  logic            cpha,
    input  logic            cs_we,
    input  logic [NCS-1:0]  cs_din,
    output logic [DW-1:0]   dout,
    output logic            busy,
    output logic            done,
    output logic [NCS-1:0]  cs_n,
    output logic            sck,
    output logic            sdo,
    input  logic            sdi
);

    localparam int EW = clog2(2 * DW);

    state_t          state_q, state_d;
    logic [DW-1:0]   tx_q, tx_d;
    logic [DW-1:0]   rx_q, rx_d;
    logic [DW-1:0]   dout_q, dout_d;
    logic [DIVW-1:0] div_q, div_d;
    logic [1:0]      mode_q, mode_d;
    logic [NCS-1:0]  cs_q, cs_d;
    logic            busy_q, busy_d, done_q, done_d, sck_q, sck_d, sdo_q, sdo_d;

    logic            edge_stb, last_edge, sample_edge;
    logic [EW-1:0]   edge_idx, nsent;
    logic [DW-1:0]   tx_shift;

    zspi_clkgen #(.DW(DW), .DIVW(DIVW), .EW(EW)) u_clkgen (
        .clk       (clk),
        .rst       (rst),
        .clr       (state_q == ST_LOAD),
        .en        (state_q == ST_RUN),
        .div       (div_q),
        .edge_stb  (edge_stb),
        .edge_idx  (edge_idx),
        .last_edge (last_edge)
    );

    // Next-state logic: FSM, serial shifting, SCK/SDO and chip-select updates
    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        dout_d  = dout_q;
        div_d   = div_q;
        mode_d  = mode_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        sck_d   = sck_q;
        sdo_d   = sdo_q;
        cs_d    = cs_we ? cs_din : cs_q;
        // Sample edges are even for CPHA=0 and odd for CPHA=1, so parity == cpha
        sample_edge = edge_stb && (edge_idx[0] == mode_q[0]);
        // Bits already on the wire before this drive edge; CPHA=0 put the MSB out at start
        nsent    = (edge_idx >> 1) + (mode_q[0] ? EW'(0) : EW'(1));
        tx_shift = tx_q << nsent;
        case (state_q)
            ST_IDLE: begin
                sck_d = cpol;
                sdo_d = 1'b1;
                if (start) begin
                    state_d = ST_LOAD;
                    busy_d  = 1'b1;
                    tx_d    = din;
                    div_d   = div;
                    mode_d  = {cpol, cpha};
                    sdo_d   = cpha ? 1'b1 : din[DW-1];
                end
            end
            ST_LOAD: state_d = ST_RUN;
            ST_RUN: begin
                if (edge_stb) sck_d = ~sck_q;
                if (sample_edge) rx_d = {rx_q[DW-2:0], sdi};
                if (edge_stb && !sample_edge) sdo_d = tx_shift[DW-1];
                if (last_edge) begin
                    state_d = ST_FIN;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    dout_d  = rx_d;
                    sdo_d   = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                sdo_d   = 1'b1;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            tx_q    <= '0;
            rx_q    <= '0;
            dout_q  <= '0;
            div_q   <= '0;
            mode_q  <= SPI_MODE0;
            cs_q    <= '1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sck_q   <= 1'b0;
            sdo_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            dout_q  <= dout_d;
            div_q   <= div_d;
            mode_q  <= mode_d;
            cs_q    <= cs_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sck_q   <= sck_d;
            sdo_q   <= sdo_d;
        end
    end

    assign dout = dout_q;
    assign busy = busy_q;
    assign done = done_q;
    assign cs_n = cs_q;
    assign sck  = sck_q;
    assign sdo  = sdo_q;

endmodule

// File: tb/tb_zspi_master.sv
// Bench for zspi_master: an SPI slave model watches SCK, feeds SDI and records
// SDO; expectations come from the mode/latency rules of the protocol.
module tb_zspi_master;
    import zspi_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // 8-bit, 2-CS instance
    logic [7:0] din_a = '0, dout_a;
    logic start_a = 0, cpol_a = 0, cpha_a = 0, cs_we_a = 0, sdi_a;
    logic busy_a, done_a, sck_a, sdo_a;
    logic [7:0] div_a = '0;
    logic [1:0] cs_din_a = 2'b11, cs_n_a;

    // 16-bit, 4-CS instance (loopback)
    logic [15:0] din_b = '0, dout_b;
    logic start_b = 0, cpol_b = 0, cpha_b = 0, cs_we_b = 0;
    logic busy_b, done_b, sck_b, sdo_b;
    logic [7:0] div_b = '0;
    logic [3:0] cs_din_b = 4'hF, cs_n_b;

    zspi_master #(.DW(8), .NCS(2), .DIVW(8)) dut_a (
        .clk(clk), .rst(rst), .din(din_a), .start(start_a), .div(div_a), .cpol(cpol_a),
        .cpha(cpha_a), .cs_we(cs_we_a), .cs_din(cs_din_a), .dout(dout_a), .busy(busy_a),
        .done(done_a), .cs_n(cs_n_a), .sck(sck_a), .sdo(sdo_a), .sdi(sdi_a));

    zspi_master #(.DW(16), .NCS(4), .DIVW(8)) dut_b (
        .clk(clk), .rst(rst), .din(din_b), .start(start_b), .div(div_b), .cpol(cpol_b),
        .cpha(cpha_b), .cs_we(cs_we_b), .cs_din(cs_din_b), .dout(dout_b), .busy(busy_b),
        .done(done_b), .cs_n(cs_n_b), .sck(sck_b), .sdo(sdo_b), .sdi(sdo_b));

    int n_checks = 0, n_pass = 0;

    // Slave model state
    bit loop_a = 0, slv_en = 0;
    logic slv_sdi = 1'b1;
    logic [7:0] slv_pat = '0, cap = '0;
    logic m_cpol = 0, m_cpha = 0, prev_sck = 0, prev_sdo = 1;
    int m_div = 0, slv_bit = 0, sck_edges = 0, half_cnt = 0, half_bad = 0;
    assign sdi_a = loop_a ? sdo_a : slv_sdi;

    // Transfer results
    int r_lat, r_ndone;
    logic [7:0] r_dout;
    logic [1:0] r_cs;
    logic r_busy1, r_idle_sck, r_sck, r_sdo, r_busy;

    // Slave: SCK edges seen one half-cycle after the clk edge that made them
    initial begin
        forever begin
            @(negedge clk);
            half_cnt++;
            if (slv_en && sck_a !== prev_sck) begin
                if (sck_edges > 0 && half_cnt != m_div + 1) half_bad++;
                half_cnt = 0;
                sck_edges++;
                if ((sck_a !== m_cpol) != m_cpha) begin
                    cap = {cap[6:0], prev_sdo};
                end else if (m_cpha) begin
                    if (slv_bit < 8) slv_sdi = slv_pat[7 - slv_bit];
                    slv_bit++;
                end else begin
                    slv_bit++;
                    if (slv_bit < 8) slv_sdi = slv_pat[7 - slv_bit];
                end
            end
            prev_sck = sck_a;
            prev_sdo = sdo_a;
        end
    end

    // inj: 1 start mid-transfer, 2 start while done, 3 cs write, 4 config change, 5 reset at edge 7
    task automatic do_xfer(input logic [1:0] mode, input int dv, input logic [7:0] data,
                           input logic [7:0] pat, input bit lp, input int inj);
        int n, rst_k;
        n = 16 * (dv + 1) + 2;
        rst_k = 0;
        @(negedge clk);
        cpol_a = mode[1]; cpha_a = mode[0]; div_a = 8'(dv); din_a = data;
        m_cpol = mode[1]; m_cpha = mode[0]; m_div = dv;
        loop_a = lp; slv_pat = pat; slv_bit = 0; slv_sdi = mode[0] ? 1'b1 : pat[7];
        cap = '0; sck_edges = 0; half_cnt = 0; half_bad = 0;
        r_lat = -1; r_ndone = 0; r_cs = cs_n_a;
        @(negedge clk);
        @(negedge clk);
        r_idle_sck = sck_a;
        slv_en = 1;
        start_a = 1;
        @(posedge clk);
        for (int k = 1; k <= n + 4; k++) begin
            @(negedge clk);
            #1;
            start_a = 0;
            cs_we_a = 0;
            if (k == 1) r_busy1 = busy_a;
            if (done_a) begin
                r_ndone++;
                if (r_lat < 0) begin
                    r_lat = k;
                    if (inj == 2) start_a = 1;
                end
                if (inj == 4) begin cpol_a = m_cpol; cpha_a = m_cpha; div_a = 8'(dv); end
            end
            if (inj == 1 && k == n / 2) begin start_a = 1; din_a = 8'hFF; end
            if (inj == 3 && k == 5) begin cs_we_a = 1; cs_din_a = 2'b10; end
            if (inj == 3 && k == 6) r_cs = cs_n_a;
            if (inj == 4 && k == 3) begin cpol_a = ~m_cpol; cpha_a = ~m_cpha; div_a = 8'(dv + 3); end
            if (inj == 5 && rst_k == 0 && sck_edges >= 7) begin
                rst = 1; rst_k = k; slv_en = 0;
                #1;
                r_sck = sck_a; r_sdo = sdo_a; r_busy = busy_a; r_cs = cs_n_a; r_dout = dout_a;
            end
            if (inj == 5 && rst_k > 0 && k == rst_k + 2) rst = 0;
        end
        slv_en = 0;
        if (inj != 5) r_dout = dout_a;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++; if (dout_a !== 8'h00) $display("FAIL rst_dout got %h want 00", dout_a); else n_pass++;
        n_checks++; if (busy_a !== 1'b0) $display("FAIL rst_busy got %b want 0", busy_a); else n_pass++;
        n_checks++; if (done_a !== 1'b0) $display("FAIL rst_done got %b want 0", done_a); else n_pass++;
        n_checks++; if (cs_n_a !== 2'b11) $display("FAIL rst_cs got %b want 11", cs_n_a); else n_pass++;
        n_checks++; if (sck_a !== 1'b0) $display("FAIL rst_sck got %b want 0", sck_a); else n_pass++;
        n_checks++; if (sdo_a !== 1'b1) $display("FAIL rst_sdo got %b want 1", sdo_a); else n_pass++;
        n_checks++; if (cs_n_b !== 4'hF) $display("FAIL rst_cs_b got %h want F", cs_n_b); else n_pass++;
        rst = 0;
        @(negedge clk);
    endtask

    task automatic test_mode0_loop();
        do_xfer(SPI_MODE0, 0, 8'hA5, 8'h00, 1, 0);
        n_checks++; if (r_lat !== 18) $display("FAIL m0_latency got %0d want 18", r_lat); else n_pass++;
        n_checks++; if (sck_edges !== 16) $display("FAIL m0_edges got %0d want 16", sck_edges); else n_pass++;
        n_checks++; if (r_dout !== 8'hA5) $display("FAIL m0_dout got %h want a5", r_dout); else n_pass++;
        n_checks++; if (cap !== 8'hA5) $display("FAIL m0_sdo got %h want a5", cap); else n_pass++;
        n_checks++; if (half_bad !== 0) $display("FAIL m0_halfper got %0d bad want 0", half_bad); else n_pass++;
        n_checks++; if (r_busy1 !== 1'b1) $display("FAIL m0_busy got %b want 1", r_busy1); else n_pass++;
        n_checks++; if (r_ndone !== 1) $display("FAIL m0_ndone got %0d want 1", r_ndone); else n_pass++;
    endtask

    task automatic test_mode3_pattern();
        do_xfer(SPI_MODE3, 3, 8'h96, 8'h3C, 0, 0);
        n_checks++; if (r_idle_sck !== 1'b1) $display("FAIL m3_idle_sck got %b want 1", r_idle_sck); else n_pass++;
        n_checks++; if (r_dout !== 8'h3C) $display("FAIL m3_dout got %h want 3c", r_dout); else n_pass++;
        n_checks++; if (cap !== 8'h96) $display("FAIL m3_sdo got %h want 96", cap); else n_pass++;
        n_checks++; if (half_bad !== 0) $display("FAIL m3_halfper got %0d bad want 0", half_bad); else n_pass++;
        n_checks++; if (r_lat !== 66) $display("FAIL m3_latency got %0d want 66", r_lat); else n_pass++;
        n_checks++; if (sck_edges !== 16) $display("FAIL m3_edges got %0d want 16", sck_edges); else n_pass++;
    endtask

    task automatic test_start_ignored();
        do_xfer(SPI_MODE2, 1, 8'h5A, 8'h00, 1, 1);
        n_checks++; if (r_dout !== 8'h5A) $display("FAIL busy_start_dout got %h want 5a", r_dout); else n_pass++;
        n_checks++; if (r_ndone !== 1) $display("FAIL busy_start_ndone got %0d want 1", r_ndone); else n_pass++;
        n_checks++; if (r_lat !== 34) $display("FAIL busy_start_latency got %0d want 34", r_lat); else n_pass++;
        do_xfer(SPI_MODE0, 0, 8'h81, 8'h7E, 0, 2);
        n_checks++; if (r_ndone !== 1) $display("FAIL done_start_ndone got %0d want 1", r_ndone); else n_pass++;
        n_checks++; if (busy_a !== 1'b0) $display("FAIL done_start_busy got %b want 0", busy_a); else n_pass++;
        n_checks++; if (r_dout !== 8'h7E) $display("FAIL done_start_dout got %h want 7e", r_dout); else n_pass++;
    endtask

    task automatic test_mid_changes();
        do_xfer(SPI_MODE1, 2, 8'h4D, 8'h00, 1, 4);
        n_checks++; if (r_lat !== 50) $display("FAIL cfg_change_latency got %0d want 50", r_lat); else n_pass++;
        n_checks++; if (r_dout !== 8'h4D) $display("FAIL cfg_change_dout got %h want 4d", r_dout); else n_pass++;
        n_checks++; if (half_bad !== 0) $display("FAIL cfg_change_halfper got %0d bad want 0", half_bad); else n_pass++;
    endtask

    task automatic test_cs_busy();
        do_xfer(SPI_MODE0, 2, 8'hC3, 8'h00, 1, 3);
        n_checks++; if (r_cs !== 2'b10) $display("FAIL cs_busy got %b want 10", r_cs); else n_pass++;
        n_checks++; if (r_dout !== 8'hC3) $display("FAIL cs_busy_dout got %h want c3", r_dout); else n_pass++;
        n_checks++; if (r_lat !== 50) $display("FAIL cs_busy_latency got %0d want 50", r_lat); else n_pass++;
    endtask

    task automatic test_rst_mid();
        do_xfer(SPI_MODE0, 1, 8'hE7, 8'h00, 1, 5);
        n_checks++; if (r_sck !== 1'b0) $display("FAIL rstmid_sck got %b want 0", r_sck); else n_pass++;
        n_checks++; if (r_sdo !== 1'b1) $display("FAIL rstmid_sdo got %b want 1", r_sdo); else n_pass++;
        n_checks++; if (r_busy !== 1'b0) $display("FAIL rstmid_busy got %b want 0", r_busy); else n_pass++;
        n_checks++; if (r_cs !== 2'b11) $display("FAIL rstmid_cs got %b want 11", r_cs); else n_pass++;
        n_checks++; if (r_dout !== 8'h00) $display("FAIL rstmid_dout got %h want 00", r_dout); else n_pass++;
        n_checks++; if (r_ndone !== 0) $display("FAIL rstmid_ndone got %0d want 0", r_ndone); else n_pass++;
        do_xfer(SPI_MODE2, 0, 8'h6E, 8'h00, 1, 0);
        n_checks++; if (r_dout !== 8'h6E) $display("FAIL rstmid_restart_dout got %h want 6e", r_dout); else n_pass++;
        n_checks++; if (r_lat !== 18) $display("FAIL rstmid_restart_latency got %0d want 18", r_lat); else n_pass++;
    endtask

    task automatic test_random();
        logic [1:0] md;
        logic [7:0] d, p, exp_d;
        int dv;
        bit lp;
        for (int i = 0; i < 7; i++) begin
            md = 2'($urandom_range(0, 3));
            dv = (i == 6) ? 255 : int'($urandom_range(0, 3));
            d = 8'($urandom); p = 8'($urandom); lp = 1'($urandom_range(0, 1));
            do_xfer(md, dv, d, p, lp, 0);
            exp_d = lp ? d : p;
            n_checks++; if (r_dout !== exp_d) $display("FAIL rand%0d_dout got %h want %h", i, r_dout, exp_d); else n_pass++;
            n_checks++; if (r_lat !== 16 * (dv + 1) + 2) $display("FAIL rand%0d_latency got %0d want %0d", i, r_lat, 16 * (dv + 1) + 2); else n_pass++;
            n_checks++; if (cap !== d) $display("FAIL rand%0d_sdo got %h want %h", i, cap, d); else n_pass++;
            n_checks++; if (half_bad !== 0 || sck_edges !== 16) $display("FAIL rand%0d_sck got %0d edges %0d bad want 16 0", i, sck_edges, half_bad); else n_pass++;
        end
    endtask

    task automatic test_dw16();
        logic [15:0] w;
        logic [1:0] md;
        logic ps;
        int lat, edges, dv, n;
        md = SPI_MODE1;
        for (int t = 0; t < 2; t++) begin
            w = (t == 0) ? 16'h1234 : 16'($urandom);
            dv = (t == 0) ? 1 : 0;
            n = 32 * (dv + 1) + 2;
            @(negedge clk);
            din_b = w; cpol_b = md[1]; cpha_b = md[0]; div_b = 8'(dv);
            @(negedge clk);
            @(negedge clk);
            ps = sck_b; edges = 0; lat = -1;
            start_b = 1;
            @(posedge clk);
            for (int k = 1; k <= n + 4; k++) begin
                @(negedge clk);
                #1;
                start_b = 0;
                if (sck_b !== ps) edges++;
                ps = sck_b;
                if (done_b === 1'b1 && lat < 0) lat = k;
            end
            n_checks++; if (dout_b !== w) $display("FAIL dw16_%0d_dout got %h want %h", t, dout_b, w); else n_pass++;
            n_checks++; if (edges !== 32) $display("FAIL dw16_%0d_edges got %0d want 32", t, edges); else n_pass++;
            n_checks++; if (lat !== n) $display("FAIL dw16_%0d_latency got %0d want %0d", t, lat, n); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_mode0_loop();
        test_mode3_pattern();
        test_start_ignored();
        test_mid_changes();
        test_cs_busy();
        test_rst_mid();
        test_random();
        test_dw16();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
